thread_cmd_requester: RTL and testbench

THREAD_CMD_REQUESTER -- requirements
Module: thread_cmd_requester

---
 rtl/thread_cmd_requester.sv | 212 +++++++++++++++++++++
 tb/tb_thread_cmd_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_cmd_requester.sv
// thread_cmd_requester
//   Queues CPU-side thread requests (RUN/STOP) and presents them one at a
//   time to the thread manager, retrying rejected commands after a back-off
//   and reporting each retirement. Next-process advance requests are merged
//   into a sticky flag and served with priority whenever the FSM is idle.
//
// Ports
//   clk, rst      clock; synchronous active-high reset (ignores clk_oe)
//   clk_oe        clock enable; when low every register holds
//   ctl_state     controller state; a command is taken on an enabled edge
//                 while ctl_state == CTL_CPU_CMD
//   req_valid/req_ready/req_op/req_data/req_addr
//                 CPU request push interface (op 0 = RUN, 1 = STOP)
//   next_req      pulse requesting a GET_NEXT_STATE command
//   thrd_cmd/thrd_data/thrd_addr
//                 command to the manager (operands zero when no RUN/STOP)
//   thrd_rslt     manager verdict, 1 = accepted, sampled one cycle after
//                 the command was taken
//   done_valid/done_ok/done_op
//                 one-cycle retirement report
//   busy          FSM active, queue non-empty or advance pending
//
// FIFO_DEPTH must be a power of two >= 2; BACKOFF_CYCLES must be >= 1.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | nothing in flight; pick pending advance first, then queue head
// NEXT      | GET_NEXT_STATE presented for one enabled cycle
// ISSUE     | head RUN/STOP presented until the controller takes it
// WAIT_RSLT | command held while the manager verdict is sampled
// BACKOFF   | rejected; idle command for BACKOFF_CYCLES before reissue
// DONE      | retirement reported, head popped
module thread_cmd_requester #(
  parameter int         FIFO_DEPTH                = 4,
  parameter int         MAX_RETRY                 = 8,
  parameter int         BACKOFF_CYCLES            = 3,
  parameter int         DATA_SIZE                 = 32,
  parameter int         ADDR_SIZE                 = 32,
  parameter logic [7:0] CTL_CPU_CMD               = 8'h05,
  parameter logic [3:0] THREAD_CMD_RUN            = 4'd1,
  parameter logic [3:0] THREAD_CMD_STOP           = 4'd2,
  parameter logic [3:0] THREAD_CMD_GET_NEXT_STATE = 4'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_oe,
  input  logic [7:0]           ctl_state,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [DATA_SIZE-1:0] req_data,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic                 next_req,
  output logic [3:0]           thrd_cmd,
  output logic [DATA_SIZE-1:0] thrd_data,
  output logic [ADDR_SIZE-1:0] thrd_addr,
  input  logic [1:0]           thrd_rslt,
  output logic                 done_valid,
  output logic                 done_ok,
  output logic                 done_op,
  output logic                 busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;
  localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int EW = 1 + DATA_SIZE + ADDR_SIZE;
  localparam logic [1:0] RSLT_ACCEPT = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_NEXT      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_RSLT = 3'd3,
    S_BACKOFF   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [BW-1:0]        boff_q, boff_d;
  logic                 ok_q, ok_d;
  logic                 next_pend_q, next_pend_d;
  logic                 push, pop;
  logic [EW-1:0]        head;
  logic                 head_op;
  logic [DATA_SIZE-1:0] head_data;
  logic [ADDR_SIZE-1:0] head_addr;

  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[EW-1];
  assign head_data = head[ADDR_SIZE +: DATA_SIZE];
  assign head_addr = head[ADDR_SIZE-1:0];

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign req_ready = (count_q < CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE) || (count_q != '0) || next_pend_q;

  // Queue bookkeeping and the sticky advance flag. A next_req arriving in
  // the NEXT cycle re-arms the flag so that pulse is not lost.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    next_pend_d = next_pend_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (next_req)                next_pend_d = 1'b1;
    else if (state_q == S_NEXT)  next_pend_d = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      retry_q     <= '0;
      boff_q      <= '0;
      ok_q        <= 1'b0;
      next_pend_q <= 1'b0;
    end else if (clk_oe) begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      retry_q     <= retry_d;
      boff_q      <= boff_d;
      ok_q        <= ok_d;
      next_pend_q <= next_pend_d;
    end
  end

  // Queue storage carries no reset; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && clk_oe && push) mem_q[wr_ptr_q] <= {req_op, req_data, req_addr};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    boff_d  = boff_q;
    ok_d    = ok_q;
    case (state_q)
      S_IDLE: begin
        if (next_pend_q) begin
          state_d = S_NEXT;
        end else if (count_q != '0) begin
          state_d = S_ISSUE;
          retry_d = '0;
        end
      end
      S_NEXT: state_d = S_IDLE;
      S_ISSUE: begin
        if (ctl_state == CTL_CPU_CMD) state_d = S_WAIT_RSLT;
      end
      S_WAIT_RSLT: begin
        if (thrd_rslt == RSLT_ACCEPT) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end else if (retry_q == RW'(MAX_RETRY - 1)) begin
          state_d = S_DONE;
          ok_d    = 1'b0;
        end else begin
          state_d = S_BACKOFF;
          retry_d = retry_q + RW'(1);
          boff_d  = BW'(BACKOFF_CYCLES - 1);
        end
      end
      S_BACKOFF: begin
        if (boff_q == '0) state_d = S_ISSUE;
        else              boff_d  = boff_q - BW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode (Moore on registered state, so outputs freeze with clk_oe)
  always_comb begin
    thrd_cmd   = 4'd0;
    thrd_data  = '0;
    thrd_addr  = '0;
    done_valid = 1'b0;
    done_ok    = 1'b0;
    done_op    = 1'b0;
    case (state_q)
      S_NEXT: thrd_cmd = THREAD_CMD_GET_NEXT_STATE;
      S_ISSUE, S_WAIT_RSLT: begin
        thrd_cmd  = head_op ? THREAD_CMD_STOP : THREAD_CMD_RUN;
        thrd_data = head_data;
        thrd_addr = head_addr;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_ok    = ok_q;
        done_op    = head_op;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_thread_cmd_requester.sv
module tb_thread_cmd_requester;
  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int MAXR = 8;
  localparam int BO   = 3;
  localparam logic [7:0] CPU_CMD = 8'h05;
  localparam logic [3:0] C_RUN  = 4'd1;
  localparam logic [3:0] C_STOP = 4'd2;
  localparam logic [3:0] C_NEXT = 4'd3;

  logic          clk = 1'b0;
  logic          rst, clk_oe;
  logic [7:0]    ctl_state;
  logic          req_valid, req_ready, req_op;
  logic [DW-1:0] req_data;
  logic [AW-1:0] req_addr;
  logic          next_req;
  logic [3:0]    thrd_cmd;
  logic [DW-1:0] thrd_data;
  logic [AW-1:0] thrd_addr;
  logic [1:0]    thrd_rslt;
  logic          done_valid, done_ok, done_op, busy;

  // Manager model drives the controller side when enabled, directed code otherwise.
  bit         mgr_en = 1'b0;
  logic [7:0] mgr_ctl = '0, dir_ctl = '0;
  logic [1:0] mgr_rslt = '0, dir_rslt = '0;
  assign ctl_state = mgr_en ? mgr_ctl : dir_ctl;
  assign thrd_rslt = mgr_en ? mgr_rslt : dir_rslt;

  thread_cmd_requester #(
    .FIFO_DEPTH(4), .MAX_RETRY(MAXR), .BACKOFF_CYCLES(BO),
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .CTL_CPU_CMD(CPU_CMD),
    .THREAD_CMD_RUN(C_RUN), .THREAD_CMD_STOP(C_STOP), .THREAD_CMD_GET_NEXT_STATE(C_NEXT)
  ) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .ctl_state(ctl_state),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_addr(req_addr), .next_req(next_req),
    .thrd_cmd(thrd_cmd), .thrd_data(thrd_data), .thrd_addr(thrd_addr),
    .thrd_rslt(thrd_rslt), .done_valid(done_valid), .done_ok(done_ok),
    .done_op(done_op), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic op; logic [DW-1:0] data; logic [AW-1:0] addr; int rej; } mreq_t;
  typedef struct { logic op; logic ok; } exp_t;
  mreq_t mgr_q[$];
  exp_t  exp_q[$];
  exp_t  mon_e;

  int vectors = 0, miscompares = 0, done_cnt = 0;
  int mgr_att = 0, gap = 0, r = 0, rej = 0, base = 0, nxt = 0, nxt_pos = 0, n = 0;
  bit res_phase = 1'b0;
  logic [3:0] prev_cmd = '0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [3:0] cmd_of(input logic op);
    return op ? C_STOP : C_RUN;
  endfunction

  // Manager model: takes each presented command after a random stall,
  // answers with the verdict scripted for that request (reject 'rej' times).
  always @(negedge clk) begin
    if (!mgr_en) begin
      res_phase = 1'b0;
      prev_cmd  = '0;
      mgr_ctl   = '0;
      mgr_rslt  = '0;
    end else begin
      if (res_phase) begin
        res_phase = 1'b0;
        mgr_ctl   = '0;
        gap       = 0;
        if (mgr_q.size() == 0) begin
          chk("mgr_queue_empty", 32'(mgr_q.size()), 32'd1);
        end else begin
          chk("wait_hold_cmd", 32'(thrd_cmd), 32'(cmd_of(mgr_q[0].op)));
          if (mgr_att < mgr_q[0].rej) begin
            mgr_rslt = 2'd0;
            mgr_att++;
            if (mgr_att == MAXR) begin
              void'(mgr_q.pop_front());
              mgr_att = 0;
            end
          end else begin
            mgr_rslt = 2'd1;
            void'(mgr_q.pop_front());
            mgr_att = 0;
          end
        end
      end else if (thrd_cmd == C_RUN || thrd_cmd == C_STOP) begin
        mgr_rslt = 2'd0;
        if (mgr_q.size() == 0) begin
          chk("unexpected_cmd", 32'(thrd_cmd), 32'd0);
        end else begin
          if (prev_cmd == 4'd0) begin
            chk("issue_cmd", 32'(thrd_cmd), 32'(cmd_of(mgr_q[0].op)));
            chk("issue_data", 32'(thrd_data), 32'(mgr_q[0].data));
            chk("issue_addr", 32'(thrd_addr), 32'(mgr_q[0].addr));
            if (mgr_att > 0) chk("backoff_gap", 32'(gap), 32'(BO));
          end
          if ($urandom_range(0, 3) != 0) begin
            mgr_ctl   = CPU_CMD;
            res_phase = 1'b1;
          end
        end
      end else begin
        mgr_ctl  = '0;
        mgr_rslt = '0;
        if (thrd_cmd == 4'd0) gap++;
      end
      prev_cmd = thrd_cmd;
    end
  end

  // Monitor: retirements against the scoreboard, idle operands always zero.
  always @(negedge clk) begin
    if (done_valid && clk_oe && !rst) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_op", 32'(done_op), 32'(mon_e.op));
        chk("done_ok", 32'(done_ok), 32'(mon_e.ok));
      end
    end
    if (thrd_cmd == 4'd0 || thrd_cmd == C_NEXT) begin
      chk("idle_data_zero", 32'(thrd_data), 32'd0);
      chk("idle_addr_zero", 32'(thrd_addr), 32'd0);
    end
  end

  task automatic push(input logic op, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input int rj, input bit to_sb, input bit to_mgr);
    int k = 0;
    req_valid = 1'b1; req_op = op; req_data = d; req_addr = a;
    while (!(req_ready && clk_oe) && k <= 3000) begin
      @(negedge clk);
      k++;
    end
    if (k > 3000) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      if (to_mgr) mgr_q.push_back('{op, d, a, rj});
      if (to_sb)  exp_q.push_back('{op, 1'(rj < MAXR)});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_for_cmd(input logic [3:0] c, input string nm);
    int k = 0;
    while (thrd_cmd != c && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(thrd_cmd), 32'(c));
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    chk({nm, "_mgr"}, 32'(mgr_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd"},   32'(thrd_cmd),   32'd0);
    chk({tag, "_data"},  32'(thrd_data),  32'd0);
    chk({tag, "_addr"},  32'(thrd_addr),  32'd0);
    chk({tag, "_ready"}, 32'(req_ready),  32'd1);
    chk({tag, "_dv"},    32'(done_valid), 32'd0);
    chk({tag, "_dok"},   32'(done_ok),    32'd0);
    chk({tag, "_dop"},   32'(done_op),    32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  task automatic manual_accept();
    dir_ctl = CPU_CMD;
    @(negedge clk);
    dir_ctl  = '0;
    dir_rslt = 2'd1;
    @(negedge clk);
    dir_rslt = 2'd0;
  endtask

  initial begin
    #900000;
    chk("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1'b1; clk_oe = 1'b1; req_valid = 1'b0; req_op = 1'b0;
    req_data = '0; req_addr = '0; next_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single RUN, accepted first try: latency and operands
    exp_q.push_back('{1'b0, 1'b1});
    req_valid = 1'b1; req_op = 1'b0; req_data = 16'h0005; req_addr = 12'h040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("lat_cmd_c1", 32'(thrd_cmd), 32'd0);
    chk("busy_after_push", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_cmd_c2", 32'(thrd_cmd), 32'(C_RUN));
    chk("run_data", 32'(thrd_data), 32'h5);
    chk("run_addr", 32'(thrd_addr), 32'h40);
    dir_ctl = CPU_CMD;
    @(negedge clk);
    dir_ctl = '0; dir_rslt = 2'd1;
    chk("wait_cmd_held", 32'(thrd_cmd), 32'(C_RUN));
    chk("no_early_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    dir_rslt = 2'd0;
    chk("done_latency", 32'(done_valid), 32'd1);
    chk("done_cmd_zero", 32'(thrd_cmd), 32'd0);
    @(negedge clk);
    chk("done_one_pulse", 32'(done_valid), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Randomized traffic against the manager model
    mgr_en = 1'b1;
    push(1'b1, 16'hA5A5, 12'h123, 2, 1'b1, 1'b1);
    push(1'b0, 16'h0F0F, 12'h0AB, 1000, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      rej = 0;
      else if (r < 8) rej = $urandom_range(1, MAXR - 1);
      else            rej = MAXR + $urandom_range(0, 3);
      push(1'($urandom_range(0, 1)), DW'($urandom), AW'($urandom), rej, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("drain_random");

    // Fill with manager stalled, fifth waits for the first retirement
    mgr_en = 1'b0;
    @(negedge clk);
    base = done_cnt;
    for (int i = 0; i < 4; i++)
      push(1'(i & 1), DW'(16'h0100 + i), AW'(12'h010 + i), 0, 1'b1, 1'b1);
    chk("full_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_op = 1'b0; req_data = 16'h01FF; req_addr = 12'h01F;
    repeat (5) @(negedge clk);
    chk("full_hold", 32'(req_ready), 32'd0);
    chk("full_no_retire", 32'(done_cnt - base), 32'd0);
    mgr_en = 1'b1;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_after_first_retire", 32'(done_cnt - base), 32'd1);
    mgr_q.push_back('{1'b0, 16'h01FF, 12'h01F, 0});
    exp_q.push_back('{1'b0, 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    drain("drain_fill");
    mgr_en = 1'b0;
    @(negedge clk);

    // Advance requests merged while a RUN is pending
    exp_q.push_back('{1'b0, 1'b1});
    req_valid = 1'b1; req_op = 1'b0; req_data = 16'h0077; req_addr = 12'h007;
    @(negedge clk);
    req_valid = 1'b0;
    wait_for_cmd(C_RUN, "next_wait_run");
    repeat (3) begin
      next_req = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      @(negedge clk);
    end
    chk("next_still_issue", 32'(thrd_cmd), 32'(C_RUN));
    manual_accept();
    chk("next_done_first", 32'(done_valid), 32'd1);
    nxt = 0; nxt_pos = -1;
    for (int k = 0; k < 8; k++) begin
      if (thrd_cmd == C_NEXT) begin
        nxt++;
        nxt_pos = k;
      end
      @(negedge clk);
    end
    chk("next_merged_count", 32'(nxt), 32'd1);
    chk("next_position", 32'(nxt_pos), 32'd2);
    chk("next_then_idle", 32'(busy), 32'd0);

    // Advance from idle
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    chk("idle_next_c1", 32'(thrd_cmd), 32'd0);
    @(negedge clk);
    chk("idle_next_c2", 32'(thrd_cmd), 32'(C_NEXT));
    @(negedge clk);
    chk("idle_next_c3", 32'(thrd_cmd), 32'd0);
    chk("idle_next_busy", 32'(busy), 32'd0);

    // Clock-enable freeze mid-ISSUE, controller asserting CPU_CMD meanwhile
    exp_q.push_back('{1'b1, 1'b1});
    req_valid = 1'b1; req_op = 1'b1; req_data = 16'h003C; req_addr = 12'h3C0;
    @(negedge clk);
    req_valid = 1'b0;
    wait_for_cmd(C_STOP, "frz_wait_stop");
    clk_oe = 1'b0; dir_ctl = CPU_CMD;
    repeat (5) begin
      @(negedge clk);
      chk("frz_cmd", 32'(thrd_cmd), 32'(C_STOP));
      chk("frz_data", 32'(thrd_data), 32'h3C);
      chk("frz_addr", 32'(thrd_addr), 32'h3C0);
      chk("frz_done", 32'(done_valid), 32'd0);
    end
    clk_oe = 1'b1; dir_ctl = '0;
    @(negedge clk);
    chk("frz_resume_issue", 32'(thrd_cmd), 32'(C_STOP));
    manual_accept();
    chk("frz_done_after", 32'(done_valid), 32'd1);
    @(negedge clk);

    // Reset in WAIT_RSLT with two more queued: everything discarded
    for (int i = 0; i < 3; i++)
      push(1'b0, DW'(16'h0200 + i), AW'(12'h200 + i), 0, 1'b0, 1'b0);
    wait_for_cmd(C_RUN, "rst_wait_run");
    dir_ctl = CPU_CMD;
    @(negedge clk);
    dir_ctl = '0; dir_rslt = 2'd1; rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0; dir_rslt = 2'd0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_cmd", 32'(thrd_cmd), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
    end
    chk("postrst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
